// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage.
//   - bit positions inside the one-hot load_op vector
//   - data-SRAM transfer size encodings
//   - request FSM state type
package mem_stage_pkg;

    // Bit positions inside load_op (one-hot)
    localparam int LD_B  = 0;
    localparam int LD_H  = 1;
    localparam int LD_W  = 2;
    localparam int LD_BU = 3;
    localparam int LD_HU = 4;
    localparam int ST_B  = 5;
    localparam int ST_H  = 6;
    localparam int ST_W  = 7;

    // data_sram_size encodings
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // IDLE: request may be issued; WAIT: request accepted, waiting for data_ok;
    // DONE: response captured in the buffer, waiting for write-back to accept.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-SRAM address/data split handshake.
//   master (memory stage): req, wr, size, wstrb, addr, wdata -> SRAM
//   slave  (SRAM)        : addr_ok, data_ok, rdata          -> stage
interface mem_stage_if;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/mem_load_align.sv
// Combinational load alignment and extension.
//   rdata    in  32  raw word returned by the data SRAM
//   addr_lo  in  2   low address bits of the load
//   ld_op    in  5   load bits of the one-hot op vector (ld.b .. ld.hu)
//   load_val out 32  aligned, sign/zero-extended load value
// Misaligned halves/words are not trapped: addr_lo[0] is ignored for halves
// and both bits for words.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [4:0]  ld_op,
    output logic [31:0] load_val
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = 8'(rdata >> {addr_lo, 3'b000});
    assign half_v = 16'(rdata >> {addr_lo[1], 4'b0000});

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        load_val = rdata;
        if (ld_op[LD_B])       load_val = {{24{byte_v[7]}}, byte_v};
        else if (ld_op[LD_H])  load_val = {{16{half_v[15]}}, half_v};
        else if (ld_op[LD_BU]) load_val = {24'b0, byte_v};
        else if (ld_op[LD_HU]) load_val = {16'b0, half_v};
        else if (ld_op[LD_W])  load_val = rdata;
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage (between execute and write-back).
// Issues at most one data-SRAM request per load/store, aligns load data and
// registers the write-back bundle under the valid/ready pipeline handshake.
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      handshake with the execute stage
//   out_valid / out_ready    handshake with write-back
//   PC, result, load_op, res_from_mem, gr_we, mem_we, dest, rkd_value
//                            execute-stage bundle (result is the address)
//   sram                     data-SRAM master port
//   final_result_out, PC_out, gr_we_out, dest_out
//                            registered bundle toward write-back
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic [31:0]        PC,
    input  logic [31:0]        result,
    input  logic [7:0]         load_op,
    input  logic               res_from_mem,
    input  logic               gr_we,
    input  logic               mem_we,
    input  logic [4:0]         dest,
    input  logic [31:0]        rkd_value,
    mem_stage_if.master        sram,
    output logic [31:0]        final_result_out,
    output logic [31:0]        PC_out,
    output logic               gr_we_out,
    output logic [4:0]         dest_out
);

    state_t      state, state_nxt;
    logic        memop, ready_go, fire, req;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata, rdata_buf, load_word, load_val, final_result;

    assign memop    = res_from_mem | mem_we;
    assign ready_go = ~memop | ((state == S_WAIT) & sram.data_ok) | (state == S_DONE);
    assign in_ready = ~rst & (~in_valid | (ready_go & out_ready));
    assign fire     = in_valid & ready_go & out_ready;

    // Request FSM: one request per instruction; data_ok outside WAIT is ignored.
    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        case (state)
            S_IDLE: begin
                req = in_valid & memop;
                if (req & sram.addr_ok) state_nxt = S_WAIT;
            end
            S_WAIT: if (sram.data_ok) state_nxt = out_ready ? S_IDLE : S_DONE;
            S_DONE: if (out_ready)    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request fields depend only on the held instruction, so they stay stable
    // for as long as req is waiting for addr_ok.
    always_comb begin
        size  = SIZE_WORD;
        wstrb = 4'b0000;
        wdata = 32'b0;
        if (load_op[LD_B] | load_op[LD_BU] | load_op[ST_B])      size = SIZE_BYTE;
        else if (load_op[LD_H] | load_op[LD_HU] | load_op[ST_H]) size = SIZE_HALF;
        if (load_op[ST_B]) begin
            wstrb = 4'b0001 << result[1:0];
            wdata = {4{rkd_value[7:0]}};
        end else if (load_op[ST_H]) begin
            wstrb = result[1] ? 4'b1100 : 4'b0011;
            wdata = {2{rkd_value[15:0]}};
        end else if (load_op[ST_W]) begin
            wstrb = 4'b1111;
            wdata = rkd_value;
        end
    end

    assign sram.req   = req;
    assign sram.wr    = mem_we;
    assign sram.size  = size;
    assign sram.wstrb = wstrb;
    assign sram.addr  = result;
    assign sram.wdata = wdata;

    // In DONE the SRAM bus no longer holds the response; use the captured copy.
    assign load_word = (state == S_DONE) ? rdata_buf : sram.rdata;

    mem_load_align u_align (
        .rdata    (load_word),
        .addr_lo  (result[1:0]),
        .ld_op    (load_op[4:0]),
        .load_val (load_val)
    );

    assign final_result = res_from_mem ? load_val : result;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rdata_buf <= 32'b0;
        end else begin
            state <= state_nxt;
            if ((state == S_WAIT) & sram.data_ok & ~out_ready) rdata_buf <= sram.rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid        <= 1'b0;
            final_result_out <= 32'b0;
            PC_out           <= RESET_PC;
            gr_we_out        <= 1'b0;
            dest_out         <= 5'b0;
        end else begin
            if (out_ready) out_valid <= in_valid & ready_go;
            if (fire) begin
                final_result_out <= final_result;
                PC_out           <= PC;
                gr_we_out        <= gr_we;
                dest_out         <= dest;
            end
        end
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage that sits directly downstream of the execute stage and upstream of write-back. It consumes the execute stage's registered result bundle and issues at most one data-SRAM request (load or store) per instruction over an address/data split handshake. It then aligns and extends load data, selects the final write-back value and registers it toward write-back under the same valid/ready pipeline handshake used by every stage.

## Interface
- RESET_PC, 32'h1c000000, reset value of PC_out
- clk  in  1  single clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction present from execute stage
- in_ready  out  1  stage accepts/consumes current instruction this cycle
- out_valid  out  1  registered valid toward write-back
- out_ready  in  1  write-back can accept
- PC  in  32  instruction PC
- result  in  32  ALU/mul/div result; memory address for loads/stores
- load_op  in  8  one-hot memory op: [0] ld.b, [1] ld.h, [2] ld.w, [3] ld.bu, [4] ld.hu, [5] st.b, [6] st.h, [7] st.w
- res_from_mem  in  1  load instruction
- gr_we  in  1  register write enable
- mem_we  in  1  store instruction
- dest  in  5  destination register
- rkd_value  in  32  store data
- data_sram_req  out  1  request valid
- data_sram_wr  out  1  1 = write
- data_sram_size  out  2  0 byte, 1 half, 2 word
- data_sram_wstrb  out  4  byte write strobes
- data_sram_addr  out  32  byte address (result, unmodified)
- data_sram_wdata  out  32  replicated store data
- data_sram_addr_ok  in  1  request accepted
- data_sram_data_ok  in  1  response (read data or write ack) valid
- data_sram_rdata  in  32  read data
- final_result_out  out  32  registered write-back value
- PC_out  out  32  registered PC
- gr_we_out  out  1  registered write enable
- dest_out  out  5  registered destination

## Operation
- memop = res_from_mem | mem_we. Non-memop instructions pass with ready_go = 1.
- FSM states IDLE, WAIT, DONE.
  - IDLE: data_sram_req = in_valid & memop. On addr_ok go to WAIT. Otherwise hold the request with stable fields.
  - WAIT: on data_ok, if out_ready the instruction is consumed and the FSM returns to IDLE. Otherwise rdata is latched into a buffer and the FSM goes to DONE.
  - DONE: uses buffered rdata; on out_ready return to IDLE.
- ready_go = ~memop | (WAIT & data_ok) | DONE.
- in_ready = ~rst & (~in_valid | ready_go & out_ready). Inputs are held stable by the upstream stage until in_ready.
- out_valid: reset 0; when out_ready, out_valid <= in_valid & ready_go.
- Output registers update only on in_valid & ready_go & out_ready.
- Store encoding:
  - st.b: size 0, wstrb = 4'b0001 << addr[1:0], wdata = rkd[7:0] replicated ×4.
  - st.h: size 1, wstrb = addr[1] ? 4'b1100 : 4'b0011, wdata = rkd[15:0] ×2.
  - st.w: size 2, wstrb 4'b1111, wdata = rkd.
- Loads drive wstrb 0 and wdata 0.
- Load extract: byte = rdata >> (8·addr[1:0]) and half = rdata >> (16·addr[1]). ld.b/ld.h sign-extend, ld.bu/ld.hu zero-extend, ld.w takes the full word. Misalignment is not checked: addr[0] is ignored for halves and addr[1:0] for words when extracting.
- final_result = res_from_mem ? load data : result.
- data_ok in IDLE is ignored.

## Timing
- Reset values: out_valid 0, final_result_out 0, PC_out RESET_PC, gr_we_out 0, dest_out 0, FSM IDLE, buffer 0.
- Non-memop latency: 1 cycle, in to out register.
- Memop minimum: req in cycle 0 with addr_ok in cycle 0, data_ok in cycle 1, output registered at edge ending cycle 1.
- addr_ok and data_ok in the same cycle in IDLE is illegal from the SRAM (data_ok refers only to an accepted request).
- Exactly one request per instruction. req deasserts in WAIT/DONE even if in_valid remains.
- rst in any state returns to IDLE and drops out_valid. A stale data_ok after reset is ignored.
- out_ready low in WAIT: data captured; the stage stalls in DONE with no second request.

## Structure
- Shared package: load_op bit-index constants (LD_B..ST_W), size encodings, FSM state enum.
- One sub-module, mem_load_align: combinational rdata/addr[1:0]/load_op -> 32-bit extended load value.

## Test plan
- ALU op (load_op 0, result 0x1234, gr_we 1, dest 5), out_ready 1 -> next cycle out_valid 1, final_result_out 0x1234, dest_out 5, no req.
- st.b addr 0x1c001003, rkd 0xAABBCCDD, addr_ok immediate, data_ok +2 cycles -> wstrb 1000, wdata 0xDDDDDDDD, size 0, in_ready high only on data_ok cycle.
- ld.b addr …02, rdata 0x00800000 -> 0xFFFFFF80; ld.bu same -> 0x00000080; ld.h addr …02, rdata 0x8001xxxx -> 0xFFFF8001.
- ld.w with addr_ok held low 3 cycles -> req held with stable addr; one request only; result equals rdata.
- data_ok while out_ready 0 for 2 cycles -> DONE, buffered value emitted when out_ready rises; no re-request.
- rst asserted in WAIT -> next cycle IDLE, out_valid 0; subsequent data_ok has no effect.
